// File: rtl/uart_tx_scheduler_pkg.sv
// Shared FSM encoding, frame counter width and counter sizing helper for the
// UART TX scheduler and its round-robin arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        GAP
    } state_t;

    localparam int unsigned FRAME_CNT_W = 16;

    // Bits needed for a counter that runs 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester-side and tx_asm-side signals of the UART TX scheduler.
// master = producers/tx_asm side, slave = the scheduler itself.
interface uart_tx_scheduler_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_parity_en;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          tx_valid;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          tx_parity_per_byte;
    logic                          tx_ready;
    logic                          tx_done;
    logic [IDX_W-1:0]              grant_id;
    logic                          busy;
    logic                          timeout_err;
    logic [FRAME_CNT_W-1:0]        frame_count;

    modport master (
        output req_valid, req_data, req_parity_en, tx_ready, tx_done,
        input  req_ready, tx_valid, tx_data, tx_parity_per_byte,
               grant_id, busy, timeout_err, frame_count
    );

    modport slave (
        input  req_valid, req_data, req_parity_en, tx_ready, tx_done,
        output req_ready, tx_valid, tx_data, tx_parity_per_byte,
               grant_id, busy, timeout_err, frame_count
    );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: the first requester above i_last_grant
// (with wrap) wins, so the previous winner has the lowest priority.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_any_req
);

    // Rank = distance above the last winner; the last winner itself ranks NUM_REQ.
    always_comb begin
        int unsigned w_rank;
        int unsigned w_best;
        o_grant     = '0;
        o_grant_idx = '0;
        w_rank      = 0;
        w_best      = NUM_REQ + 1;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            w_rank = (j > 32'(i_last_grant)) ? (j - 32'(i_last_grant))
                                             : (j + NUM_REQ - 32'(i_last_grant));
            if (i_req[j] && (w_rank < w_best)) begin
                w_best      = w_rank;
                o_grant     = '0;
                o_grant[j]  = 1'b1;
                o_grant_idx = IDX_W'(j);
            end
        end
    end

    assign o_any_req = |i_req;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one tx_asm byte-frame transmitter between NUM_REQ byte sources with
// round-robin arbitration, an inter-frame idle gap and a tx_done watchdog.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input logic              clk,
    input logic              rst,
    uart_tx_scheduler_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned TO_W  = cnt_width(TIMEOUT_CYCLES);
    localparam int unsigned GAP_W = cnt_width(GAP_CYCLES);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam state_t POST_DONE = (GAP_CYCLES > 0) ? GAP : IDLE;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [IDX_W-1:0]       r_last_grant;
    logic [IDX_W-1:0]       r_grant_id;
    logic [IDX_W-1:0]       w_grant_idx;
    logic [NUM_REQ-1:0]     w_grant;
    logic [NUM_REQ-1:0]     w_req_ready;
    logic                   w_any_req;
    logic [DATA_WIDTH-1:0]  r_tx_data;
    logic [DATA_WIDTH-1:0]  w_sel_data;
    logic                   r_tx_par;
    logic                   w_sel_par;
    logic [TO_W-1:0]        r_to_cnt;
    logic [GAP_W-1:0]       r_gap_cnt;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic                   w_accept;
    logic                   w_tx_valid;
    logic                   w_frame_done;
    logic                   w_timeout;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_req        (bus.req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx),
        .o_any_req    (w_any_req)
    );

    always_comb begin
        w_sel_data = '0;
        w_sel_par  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_par  = bus.req_parity_en[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_req_ready  = '0;
        w_accept     = 1'b0;
        w_tx_valid   = 1'b0;
        w_frame_done = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_req_ready  = w_grant;
                    w_accept     = 1'b1;
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                w_tx_valid = 1'b1;
                if (bus.tx_ready) w_next_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                // tx_done takes precedence over a coincident watchdog expiry.
                if (bus.tx_done) begin
                    w_frame_done = 1'b1;
                    w_next_state = POST_DONE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = POST_DONE;
                end
            end
            GAP: begin
                if (r_gap_cnt == GAP_LAST) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_grant_id   <= '0;
            r_tx_data    <= '0;
            r_tx_par     <= 1'b0;
            r_to_cnt     <= '0;
            r_gap_cnt    <= '0;
            r_frame_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_tx_data    <= w_sel_data;
                r_tx_par     <= w_sel_par;
                r_grant_id   <= w_grant_idx;
                r_last_grant <= w_grant_idx;
            end
            if ((r_state == WAIT_DONE) && (w_next_state == WAIT_DONE))
                r_to_cnt <= r_to_cnt + 1'b1;
            else
                r_to_cnt <= '0;
            if ((r_state == GAP) && (w_next_state == GAP))
                r_gap_cnt <= r_gap_cnt + 1'b1;
            else
                r_gap_cnt <= '0;
            if (w_frame_done)
                r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign bus.req_ready          = w_req_ready;
    assign bus.tx_valid           = w_tx_valid;
    assign bus.tx_data            = r_tx_data;
    assign bus.tx_parity_per_byte = r_tx_par;
    assign bus.grant_id           = r_grant_id;
    assign bus.busy               = (r_state != IDLE);
    assign bus.timeout_err        = w_timeout;
    assign bus.frame_count        = r_frame_cnt;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: table of arbitration vectors plus
// hand sequences for backpressure, watchdog and mid-frame reset.
module tb_uart_tx_scheduler;

    localparam int unsigned DW  = 8;
    localparam int unsigned NR  = 4;
    localparam int unsigned GPC = 2;
    localparam int unsigned TOC = 16;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  par;
        logic [3:0]  exp_ready;
        logic [1:0]  exp_id;
        logic [7:0]  exp_data;
        logic        exp_par;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail = 0;
    int   exp_frames = 0;
    vec_t vecs[11];

    uart_tx_scheduler_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    uart_tx_scheduler #(
        .DATA_WIDTH     (DW),
        .NUM_REQ        (NR),
        .GAP_CYCLES     (GPC),
        .TIMEOUT_CYCLES (TOC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        n_fail++;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    function automatic vec_t mk(input logic [3:0] valid, input logic [31:0] data,
                                input logic [3:0] par, input logic [3:0] er,
                                input logic [1:0] eid, input logic [7:0] ed, input logic ep);
        vec_t v;
        v.valid = valid; v.data = data; v.par = par;
        v.exp_ready = er; v.exp_id = eid; v.exp_data = ed; v.exp_par = ep;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"},   32'(bus.req_ready), 0);
        check({tag, "_tx_valid"},    32'(bus.tx_valid), 0);
        check({tag, "_tx_data"},     32'(bus.tx_data), 0);
        check({tag, "_tx_parity"},   32'(bus.tx_parity_per_byte), 0);
        check({tag, "_grant_id"},    32'(bus.grant_id), 0);
        check({tag, "_busy"},        32'(bus.busy), 0);
        check({tag, "_timeout_err"}, 32'(bus.timeout_err), 0);
        check({tag, "_frame_count"}, 32'(bus.frame_count), 0);
    endtask

    // Entered just after a negedge (or posedge+1); returns at the negedge in ISSUE.
    task automatic start_frame(input vec_t v, input bit chk_lat);
        int n;
        n = 1;
        bus.req_valid     = v.valid;
        bus.req_data      = v.data;
        bus.req_parity_en = v.par;
        do begin
            @(negedge clk);
            n++;
        end while ((bus.req_ready == '0) && (n < 30));
        if (chk_lat) check("done_to_ready_latency", 32'(n), 32'(GPC + 1));
        check("req_ready_onehot", 32'(bus.req_ready), 32'(v.exp_ready));
        check("busy_in_idle", 32'(bus.busy), 0);
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(negedge clk);
        check("tx_valid_issue", 32'(bus.tx_valid), 1);
        check("tx_data", 32'(bus.tx_data), 32'(v.exp_data));
        check("tx_parity", 32'(bus.tx_parity_per_byte), 32'(v.exp_par));
        check("grant_id", 32'(bus.grant_id), 32'(v.exp_id));
        check("req_ready_issue", 32'(bus.req_ready), 0);
        check("busy_issue", 32'(bus.busy), 1);
    endtask

    // From the negedge in ISSUE with tx_ready high: complete the frame with tx_done.
    task automatic finish_frame();
        @(posedge clk); #1;
        @(negedge clk);
        check("tx_valid_wait", 32'(bus.tx_valid), 0);
        check("busy_wait", 32'(bus.busy), 1);
        @(posedge clk); #1;
        bus.tx_done = 1'b1;
        @(posedge clk); #1;
        bus.tx_done = 1'b0;
        exp_frames++;
        @(negedge clk);
        check("frame_count", 32'(bus.frame_count), 32'(exp_frames));
        check("busy_gap", 32'(bus.busy), 1);
    endtask

    initial begin
        vecs[0]  = mk(4'b0001, 32'hA3A2A13C, 4'b0001, 4'b0001, 2'd0, 8'h3C, 1'b1);
        vecs[1]  = mk(4'b1111, 32'hA3A2A1A0, 4'b0101, 4'b0010, 2'd1, 8'hA1, 1'b0);
        vecs[2]  = mk(4'b1111, 32'hA3A2A1A0, 4'b0101, 4'b0100, 2'd2, 8'hA2, 1'b1);
        vecs[3]  = mk(4'b1111, 32'hA3A2A1A0, 4'b0101, 4'b1000, 2'd3, 8'hA3, 1'b0);
        vecs[4]  = mk(4'b1111, 32'hA3A2A1A0, 4'b0101, 4'b0001, 2'd0, 8'hA0, 1'b1);
        vecs[5]  = mk(4'b0010, 32'hA3A2A1A0, 4'b0101, 4'b0010, 2'd1, 8'hA1, 1'b0);
        vecs[6]  = mk(4'b1010, 32'hA3A2A1A0, 4'b0101, 4'b1000, 2'd3, 8'hA3, 1'b0);
        vecs[7]  = mk(4'b1010, 32'hA3A2A1A0, 4'b0101, 4'b0010, 2'd1, 8'hA1, 1'b0);
        vecs[8]  = mk(4'b0001, 32'hA3A2A155, 4'b0000, 4'b0001, 2'd0, 8'h55, 1'b0);
        vecs[9]  = mk(4'b1100, 32'h8877A1A0, 4'b1000, 4'b0100, 2'd2, 8'h77, 1'b0);
        vecs[10] = mk(4'b1100, 32'h8877A1A0, 4'b1000, 4'b1000, 2'd3, 8'h88, 1'b1);

        rst               = 1'b1;
        bus.req_valid     = '0;
        bus.req_data      = '0;
        bus.req_parity_en = '0;
        bus.tx_ready      = 1'b1;
        bus.tx_done       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            start_frame(vecs[i], i > 0);
            finish_frame();
        end

        // Backpressure: tx_ready low, tx_done during ISSUE must be ignored.
        bus.tx_ready = 1'b0;
        start_frame(mk(4'b0100, 32'h00C50000, 4'b0100, 4'b0100, 2'd2, 8'hC5, 1'b1), 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            bus.tx_done = (k == 3);
            @(negedge clk);
            check("bp_tx_valid", 32'(bus.tx_valid), 1);
            check("bp_tx_data", 32'(bus.tx_data), 32'h C5);
            check("bp_frame_count", 32'(bus.frame_count), 32'(exp_frames));
        end
        @(posedge clk); #1;
        bus.tx_done  = 1'b0;
        bus.tx_ready = 1'b1;
        @(negedge clk);
        check("bp_tx_valid_ready_cycle", 32'(bus.tx_valid), 1);
        finish_frame();

        // Watchdog: no tx_done, error pulse on the 16th WAIT_DONE cycle.
        start_frame(mk(4'b0001, 32'h0000005A, 4'b0000, 4'b0001, 2'd0, 8'h5A, 1'b0), 1'b1);
        @(posedge clk); #1;
        for (int k = 1; k <= int'(TOC); k++) begin
            @(negedge clk);
            check($sformatf("wd_timeout_err_c%0d", k), 32'(bus.timeout_err), 32'(k == int'(TOC)));
        end
        @(negedge clk);
        check("wd_timeout_err_after", 32'(bus.timeout_err), 0);
        check("wd_frame_count", 32'(bus.frame_count), 32'(exp_frames));
        check("wd_busy_gap", 32'(bus.busy), 1);

        // Coincident tx_done and expiry: tx_done wins, no error.
        start_frame(mk(4'b0100, 32'h00690000, 4'b0000, 4'b0100, 2'd2, 8'h69, 1'b0), 1'b1);
        @(posedge clk); #1;
        for (int k = 1; k < int'(TOC); k++) begin
            @(negedge clk);
            check("co_timeout_err_early", 32'(bus.timeout_err), 0);
        end
        @(posedge clk); #1;
        bus.tx_done = 1'b1;
        @(negedge clk);
        check("co_timeout_err", 32'(bus.timeout_err), 0);
        @(posedge clk); #1;
        bus.tx_done = 1'b0;
        exp_frames++;
        @(negedge clk);
        check("co_frame_count", 32'(bus.frame_count), 32'(exp_frames));

        // Reset in WAIT_DONE abandons the byte and restarts arbitration at 0.
        start_frame(mk(4'b1000, 32'hE1000000, 4'b1000, 4'b1000, 2'd3, 8'hE1, 1'b1), 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_all_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        exp_frames = 0;
        start_frame(mk(4'b1111, 32'hA3A2A1A0, 4'b0101, 4'b0001, 2'd0, 8'hA0, 1'b1), 1'b0);
        finish_frame();
        start_frame(mk(4'b1111, 32'hA3A2A1A0, 4'b0101, 4'b0010, 2'd1, 8'hA1, 1'b0), 1'b1);
        finish_frame();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
